// File: rtl/busarb_rr.sv
// Round-robin arbiter for three bus masters with registered one-hot grants.
// Each grant has a bounded tenure, and every ownership change passes through a dead turnaround cycle.
module busarb_rr #(
  parameter int NREQ     = 3,
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] done,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      owner,
  output logic            busy,
  output logic            timeout
);

  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [1:0]    ptr_reg;

  // Search ptr+1, ptr+2, ptr+3 (mod NREQ); walk farthest-first so the nearest requester wins.
  function automatic logic [2:0] pick_next(input logic [1:0] p, input logic [NREQ-1:0] r);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = NREQ; k >= 1; k--) begin
      idx = 2'((int'(p) + k) % NREQ);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic [2:0] pick;
  logic       owner_req;
  logic       owner_done;
  logic       hit_max;
  logic       release_now;

  always_comb begin
    pick        = pick_next(ptr_reg, req);
    owner_req   = req[owner];
    owner_done  = done[owner];
    hit_max     = (cnt_reg == CW'(MAX_HOLD));
    release_now = !owner_req || owner_done || hit_max;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      gnt       <= '0;
      owner     <= 2'd0;
      busy      <= 1'b0;
      timeout   <= 1'b0;
      cnt_reg   <= '0;
      ptr_reg   <= 2'd2;
    end else begin
      timeout <= 1'b0;
      case (state_reg)
        IDLE, TURN: begin
          if (pick[2]) begin
            gnt       <= NREQ'(1) << pick[1:0];
            owner     <= pick[1:0];
            busy      <= 1'b1;
            cnt_reg   <= CW'(1);
            state_reg <= GRANT;
          end else begin
            gnt       <= '0;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        GRANT: begin
          if (release_now) begin
            gnt       <= '0;
            busy      <= 1'b0;
            ptr_reg   <= owner;
            cnt_reg   <= '0;
            state_reg <= TURN;
            // A voluntary release (req low or done) on the final cycle is not a timeout.
            timeout   <= hit_max && owner_req && !owner_done;
          end else if (!hit_max) begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: begin
          gnt       <= '0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_busarb_rr.sv
// Bench for busarb_rr: directed scenarios plus random traffic.
// Every DUT output is compared each cycle against a cycle-level behavioural model.
module tb_busarb_rr;
  localparam int MAX_HOLD = 8;

  logic       clk;
  logic       rst;
  logic [2:0] req;
  logic [2:0] done;
  logic [2:0] gnt;
  logic [1:0] owner;
  logic       busy;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  // Model: owner (-1 = bus free), tenure so far, last owner, timeout flag for this cycle.
  int m_own;
  int m_cnt;
  int m_ptr;
  bit m_to;

  busarb_rr #(.NREQ(3), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .owner(owner), .busy(busy), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_own = -1;
    m_cnt = 0;
    m_ptr = 2;
    m_to  = 1'b0;
  endtask

  // One clock edge of arbiter behaviour, stated in terms of owners and tenure.
  task automatic model_step(input logic [2:0] r, input logic [2:0] d);
    m_to = 1'b0;
    if (m_own >= 0) begin
      if (!r[m_own] || d[m_own] || m_cnt == MAX_HOLD) begin
        m_to  = (m_cnt == MAX_HOLD) && r[m_own] && !d[m_own];
        m_ptr = m_own;
        m_own = -1;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end else begin
      for (int k = 1; k <= 3; k++) begin
        if (m_own < 0 && r[(m_ptr + k) % 3]) begin
          m_own = (m_ptr + k) % 3;
          m_cnt = 1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [2:0] exp_gnt;
    exp_gnt = (m_own >= 0) ? 3'(1 << m_own) : 3'b000;
    check("gnt", 8'(gnt), 8'(exp_gnt));
    check("busy", 8'(busy), 8'(m_own >= 0));
    check("timeout", 8'(timeout), 8'(m_to));
    if (m_own >= 0) check("owner", 8'(owner), 8'(m_own));
    $display("t=%0t req=%b done=%b gnt=%b owner=%0d busy=%b timeout=%b",
             $time, req, done, gnt, owner, busy, timeout);
  endtask

  task automatic cycle(input logic [2:0] r, input logic [2:0] d);
    req  = r;
    done = d;
    @(posedge clk);
    model_step(r, d);
    #1;
    check_outputs();
  endtask

  // Asserts reset between edges and confirms the outputs clear without waiting for a clock.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_async_gnt", 8'(gnt), 8'h00);
    check("rst_async_busy", 8'(busy), 8'h00);
    check("rst_async_timeout", 8'(timeout), 8'h00);
    model_reset();
    @(posedge clk);
    #1;
    check("rst_hold_gnt", 8'(gnt), 8'h00);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] r;
    logic [2:0] d;
    rst  = 1'b0;
    req  = 3'b111;
    done = 3'b000;
    model_reset();
    #3;

    // Reset with every master requesting; requester 0 wins the first arbitration.
    do_reset();
    cycle(3'b111, 3'b000);
    check("first_grant", 8'(gnt), 8'h01);

    // Rotation: each owner signals done on its second grant cycle.
    for (int i = 0; i < 12; i++) begin
      d = (m_own >= 0 && m_cnt == 2) ? 3'(1 << m_own) : 3'b000;
      cycle(3'b111, d);
    end

    // Sole requester times out and is re-granted after the turnaround cycle.
    do_reset();
    for (int i = 0; i < 22; i++) cycle(3'b010, 3'b000);

    // Owner drops req on the cycle its tenure hits the limit: no timeout pulse.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      r = (m_own == 1 && m_cnt == MAX_HOLD) ? 3'b000 : 3'b010;
      cycle(r, 3'b000);
    end

    // Owner 2 releases with requesters 0 and 2 active; requester 0 is next.
    do_reset();
    cycle(3'b100, 3'b000);
    cycle(3'b101, 3'b000);
    cycle(3'b101, 3'b100);
    cycle(3'b101, 3'b000);
    check("after_owner2", 8'(gnt), 8'h01);

    // A done pulse from a non-owner leaves the grant alone.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(3'b011, 3'b010);

    // Reset in the middle of a grant, then restart with req=110.
    do_reset();
    cycle(3'b100, 3'b000);
    cycle(3'b100, 3'b000);
    do_reset();
    cycle(3'b110, 3'b000);
    check("restart_grant", 8'(gnt), 8'h02);

    // Random traffic; each req bit is high about 3/4 of the time, done pulses rarely.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      for (int b = 0; b < 3; b++) begin
        r[b] = ($urandom_range(0, 3) != 0);
        d[b] = ($urandom_range(0, 9) == 0);
      end
      cycle(r, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
